// File: rtl/bambu_ext_mem_responder.sv
// Fixed-latency, byte-wide memory responder for the M_* master port of a Bambu accelerator.
// Completions travel down per-channel shift registers; index 0 of each register drives the outputs.
module bambu_ext_mem_responder #(
  parameter int                CHANNELS    = 2,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 8,
  parameter int                SIZE_W      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                DEPTH       = 256,
  parameter int                READ_DELAY  = 2,
  parameter int                WRITE_DELAY = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          M_oe_ram,
  input  logic [CHANNELS-1:0]          M_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0]   M_addr_ram,
  input  logic [CHANNELS*DATA_W-1:0]   M_Wdata_ram,
  input  logic [CHANNELS*SIZE_W-1:0]   M_data_ram_size,
  output logic [CHANNELS*DATA_W-1:0]   M_Rdata_ram,
  output logic [CHANNELS-1:0]          M_DataRdy,
  input  logic                         init_we,
  input  logic [ADDR_W-1:0]            init_addr,
  input  logic [DATA_W-1:0]            init_data,
  output logic                         err_conflict,
  output logic                         err_oob
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT   = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;

  logic [ADDR_W:0]     diff   [CHANNELS];
  logic [IDX_W-1:0]    idx    [CHANNELS];
  logic [SIZE_W-1:0]   sz     [CHANNELS];
  logic [DATA_W-1:0]   wmask  [CHANNELS];
  logic [CHANNELS-1:0] in_rng;
  logic [CHANNELS-1:0] rd_acc;
  logic [CHANNELS-1:0] wr_acc;
  logic [ADDR_W:0]     init_diff;
  logic                init_rng;
  logic [IDX_W-1:0]    init_idx;

  logic [DATA_W-1:0]   mem_q  [DEPTH];
  logic [DATA_W-1:0]   mem_d  [DEPTH];
  logic [LAT-1:0]      rdy_q  [CHANNELS];
  logic [LAT-1:0]      rdy_d  [CHANNELS];
  logic [DATA_W-1:0]   rdat_q [CHANNELS][READ_DELAY];
  logic [DATA_W-1:0]   rdat_d [CHANNELS][READ_DELAY];
  logic                err_conflict_q, err_conflict_d;
  logic                err_oob_q, err_oob_d;

  // Request decode; the extra diff bit flags addresses below BASE_ADDR.
  always_comb begin
    in_rng = '0;
    rd_acc = '0;
    wr_acc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      diff[c]   = {1'b0, M_addr_ram[c*ADDR_W +: ADDR_W]} - {1'b0, BASE_ADDR};
      in_rng[c] = !diff[c][ADDR_W] && (diff[c][ADDR_W-1:0] < ADDR_W'(DEPTH));
      idx[c]    = diff[c][IDX_W-1:0];
      sz[c]     = M_data_ram_size[c*SIZE_W +: SIZE_W];
      wr_acc[c] = M_we_ram[c];
      rd_acc[c] = M_oe_ram[c] & ~M_we_ram[c];
      for (int b = 0; b < DATA_W; b++) begin
        wmask[c][b] = (sz[c] == '0) || (32'(sz[c]) > DATA_W) || (b < 32'(sz[c]));
      end
    end
    init_diff = {1'b0, init_addr} - {1'b0, BASE_ADDR};
    init_rng  = !init_diff[ADDR_W] && (init_diff[ADDR_W-1:0] < ADDR_W'(DEPTH));
    init_idx  = init_diff[IDX_W-1:0];
  end

  // Later writers override earlier ones: init first, then channels in ascending order.
  always_comb begin
    mem_d = mem_q;
    if (init_we && init_rng) begin
      mem_d[init_idx] = init_data;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_acc[c] && in_rng[c]) begin
        mem_d[idx[c]] = (mem_d[idx[c]] & ~wmask[c])
                      | (M_Wdata_ram[c*DATA_W +: DATA_W] & wmask[c]);
      end
    end
  end

  // A read and a write landing in the same slot merge into one pulse carrying the read data.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      rdy_d[c] = rdy_q[c] >> 1;
      if (rd_acc[c]) rdy_d[c][READ_DELAY-1] = 1'b1;
      if (wr_acc[c]) rdy_d[c][WRITE_DELAY-1] = 1'b1;
      for (int i = 0; i < READ_DELAY-1; i++) begin
        rdat_d[c][i] = rdat_q[c][i+1];
      end
      rdat_d[c][READ_DELAY-1] = (rd_acc[c] && in_rng[c]) ? mem_q[idx[c]] : '0;
    end
    err_conflict_d = err_conflict_q | (|(M_oe_ram & M_we_ram));
    err_oob_d      = err_oob_q | (|((rd_acc | wr_acc) & ~in_rng));
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        rdy_q[c] <= '0;
        for (int i = 0; i < READ_DELAY; i++) begin
          rdat_q[c][i] <= '0;
        end
      end
      err_conflict_q <= 1'b0;
      err_oob_q      <= 1'b0;
    end else begin
      rdy_q          <= rdy_d;
      rdat_q         <= rdat_d;
      err_conflict_q <= err_conflict_d;
      err_oob_q      <= err_oob_d;
    end
  end

  always_comb begin
    M_DataRdy   = '0;
    M_Rdata_ram = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      M_DataRdy[c]                     = rdy_q[c][0];
      M_Rdata_ram[c*DATA_W +: DATA_W]  = rdat_q[c][0];
    end
  end

  assign err_conflict = err_conflict_q;
  assign err_oob      = err_oob_q;

endmodule

// File: tb/tb_bambu_ext_mem_responder.sv
// Bench for bambu_ext_mem_responder: a cycle-scheduled reference model predicts every output,
// with directed scenarios plus a randomized back-to-back run.
module tb_bambu_ext_mem_responder;
  localparam int CH = 2, AW = 32, DW = 8, SW = 4, DEPTH = 256, RD = 2, WD = 1;
  localparam logic [31:0] BASE = 32'h0;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [CH-1:0]     M_oe_ram, M_we_ram;
  logic [CH*AW-1:0]  M_addr_ram;
  logic [CH*DW-1:0]  M_Wdata_ram;
  logic [CH*SW-1:0]  M_data_ram_size;
  logic [CH*DW-1:0]  M_Rdata_ram;
  logic [CH-1:0]     M_DataRdy;
  logic              init_we;
  logic [AW-1:0]     init_addr;
  logic [DW-1:0]     init_data;
  logic              err_conflict, err_oob;

  bambu_ext_mem_responder #(
    .CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .BASE_ADDR(BASE),
    .DEPTH(DEPTH), .READ_DELAY(RD), .WRITE_DELAY(WD)
  ) dut (
    .clock(clock), .reset(reset),
    .M_oe_ram(M_oe_ram), .M_we_ram(M_we_ram), .M_addr_ram(M_addr_ram),
    .M_Wdata_ram(M_Wdata_ram), .M_data_ram_size(M_data_ram_size),
    .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .err_conflict(err_conflict), .err_oob(err_oob)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: byte array, sticky flags, and completions keyed by the absolute cycle they appear in.
  logic [7:0]       mem_m [DEPTH];
  logic             conf_m = 1'b0, oob_m = 1'b0;
  logic [CH-1:0]    sched_v [int];
  logic [CH*DW-1:0] sched_d [int];
  logic [CH-1:0]    e_rdy;
  logic [CH*DW-1:0] e_dat;
  logic             e_conf, e_oob;

  function automatic bit in_range(logic [31:0] a);
    return ({32'b0, a} >= {32'b0, BASE}) && ({32'b0, a} < {32'b0, BASE} + 64'(DEPTH));
  endfunction

  function automatic void sched(int when, int c, logic [7:0] d);
    logic [CH-1:0]    v;
    logic [CH*DW-1:0] dd;
    v  = sched_v.exists(when) ? sched_v[when] : '0;
    dd = sched_d.exists(when) ? sched_d[when] : '0;
    v[c] = 1'b1;
    dd[c*DW +: DW] = dd[c*DW +: DW] | d;
    sched_v[when] = v;
    sched_d[when] = dd;
  endfunction

  task automatic tick();
    logic [31:0] a;
    logic [3:0]  sz;
    logic [7:0]  m;
    int          eff;
    for (int c = 0; c < CH; c++) begin
      a = M_addr_ram[c*AW +: AW];
      if (M_we_ram[c]) begin
        sched(cyc + WD, c, 8'h00);
        if (M_oe_ram[c]) conf_m = 1'b1;
      end else if (M_oe_ram[c]) begin
        sched(cyc + RD, c, in_range(a) ? mem_m[8'(a - BASE)] : 8'h00);
      end
      if ((M_oe_ram[c] | M_we_ram[c]) && !in_range(a)) oob_m = 1'b1;
    end
    if (init_we && in_range(init_addr)) mem_m[8'(init_addr - BASE)] = init_data;
    for (int c = 0; c < CH; c++) begin
      a  = M_addr_ram[c*AW +: AW];
      sz = M_data_ram_size[c*SW +: SW];
      if (M_we_ram[c] && in_range(a)) begin
        eff = (sz == 0 || sz > 8) ? 8 : int'(sz);
        m   = 8'((1 << eff) - 1);
        mem_m[8'(a - BASE)] = (mem_m[8'(a - BASE)] & ~m) | (M_Wdata_ram[c*DW +: DW] & m);
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    e_rdy = sched_v.exists(cyc) ? sched_v[cyc] : '0;
    e_dat = sched_d.exists(cyc) ? sched_d[cyc] : '0;
    if (sched_v.exists(cyc)) begin
      sched_v.delete(cyc);
      sched_d.delete(cyc);
    end
    e_conf = conf_m;
    e_oob  = oob_m;
  endtask

  task automatic idle();
    M_oe_ram = '0; M_we_ram = '0; M_addr_ram = '0; M_Wdata_ram = '0;
    M_data_ram_size = '0; init_we = 1'b0; init_addr = '0; init_data = '0;
  endtask

  task automatic req(input int c, input logic oe, input logic we, input logic [31:0] a,
                     input logic [7:0] w, input logic [3:0] sz);
    M_oe_ram[c] = oe;
    M_we_ram[c] = we;
    M_addr_ram[c*AW +: AW] = a;
    M_Wdata_ram[c*DW +: DW] = w;
    M_data_ram_size[c*SW +: SW] = sz;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if (M_DataRdy !== '0 || M_Rdata_ram !== '0 || err_conflict !== 1'b0 || err_oob !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state rdy=%b rdata=%h conf=%b oob=%b, required all zero",
               M_DataRdy, M_Rdata_ram, err_conflict, err_oob);
    end
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) preload(BASE + 32'(i), 8'($urandom));
  endtask

  task automatic test_read_latency();
    preload(32'h10, 8'hA5);
    req(0, 1'b1, 1'b0, 32'h10, 8'h00, 4'd8);
    for (int k = 1; k <= 3; k++) begin
      tick();
      idle();
      n_tests += 2;
      if (M_DataRdy !== e_rdy || M_Rdata_ram !== e_dat || err_conflict !== e_conf || err_oob !== e_oob) begin
        n_fail++;
        $display("FAIL read_lat_model t+%0d rdy=%b/%b rdata=%h/%h conf=%b/%b oob=%b/%b (got/req)",
                 k, M_DataRdy, e_rdy, M_Rdata_ram, e_dat, err_conflict, e_conf, err_oob, e_oob);
      end
      if (M_DataRdy[0] !== (k == 2) || M_Rdata_ram[7:0] !== ((k == 2) ? 8'hA5 : 8'h00)) begin
        n_fail++;
        $display("FAIL read_lat_a5 t+%0d rdy0=%b rdata0=%h, required %b %h",
                 k, M_DataRdy[0], M_Rdata_ram[7:0], (k == 2), (k == 2) ? 8'hA5 : 8'h00);
      end
    end
  endtask

  task automatic test_write_read();
    req(1, 1'b0, 1'b1, 32'h20, 8'h3C, 4'd8);
    tick();
    idle();
    n_tests += 2;
    if (M_DataRdy !== e_rdy || M_Rdata_ram !== e_dat || err_conflict !== e_conf || err_oob !== e_oob) begin
      n_fail++;
      $display("FAIL write_ack_model rdy=%b/%b rdata=%h/%h (got/req)", M_DataRdy, e_rdy, M_Rdata_ram, e_dat);
    end
    if (M_DataRdy[1] !== 1'b1 || M_Rdata_ram[15:8] !== 8'h00) begin
      n_fail++;
      $display("FAIL write_ack rdy1=%b rdata1=%h, required 1 00", M_DataRdy[1], M_Rdata_ram[15:8]);
    end
    req(0, 1'b1, 1'b0, 32'h20, 8'h00, 4'd8);
    for (int k = 1; k <= 2; k++) begin
      tick();
      idle();
      n_tests++;
      if (M_DataRdy !== e_rdy || M_Rdata_ram !== e_dat || err_conflict !== e_conf || err_oob !== e_oob) begin
        n_fail++;
        $display("FAIL write_read_model k=%0d rdy=%b/%b rdata=%h/%h (got/req)", k, M_DataRdy, e_rdy, M_Rdata_ram, e_dat);
      end
    end
    n_tests++;
    if (M_DataRdy[0] !== 1'b1 || M_Rdata_ram[7:0] !== 8'h3C) begin
      n_fail++;
      $display("FAIL write_read_3c rdy0=%b rdata0=%h, required 1 3c", M_DataRdy[0], M_Rdata_ram[7:0]);
    end
  endtask

  task automatic test_partial_write();
    logic [3:0] szs [3];
    logic [7:0] wds [3];
    logic [7:0] exps [3];
    szs = '{4'd4, 4'd0, 4'd12};
    wds = '{8'h00, 8'h5A, 8'h3C};
    exps = '{8'hF0, 8'h5A, 8'h3C};
    preload(32'h40, 8'hFF);
    for (int j = 0; j < 3; j++) begin
      req(0, 1'b0, 1'b1, 32'h40, wds[j], szs[j]);
      tick();
      idle();
      req(0, 1'b1, 1'b0, 32'h40, 8'h00, 4'd8);
      for (int k = 1; k <= 2; k++) begin
        tick();
        idle();
        n_tests++;
        if (M_DataRdy !== e_rdy || M_Rdata_ram !== e_dat || err_conflict !== e_conf || err_oob !== e_oob) begin
          n_fail++;
          $display("FAIL partial_model size=%0d rdy=%b/%b rdata=%h/%h (got/req)", szs[j], M_DataRdy, e_rdy, M_Rdata_ram, e_dat);
        end
      end
      n_tests++;
      if (M_DataRdy[0] !== 1'b1 || M_Rdata_ram[7:0] !== exps[j]) begin
        n_fail++;
        $display("FAIL partial_size%0d rdata0=%h, required %h", szs[j], M_Rdata_ram[7:0], exps[j]);
      end
    end
  endtask

  task automatic test_hazards();
    preload(32'h30, 8'h11);
    preload(32'h31, 8'h00);
    preload(32'h32, 8'h00);
    req(0, 1'b1, 1'b0, 32'h30, 8'h00, 4'd8);
    req(1, 1'b0, 1'b1, 32'h30, 8'h22, 4'd8);
    for (int k = 1; k <= 2; k++) begin
      tick();
      idle();
      if (k == 1) begin
        req(0, 1'b0, 1'b1, 32'h31, 8'h77, 4'd8);
        req(1, 1'b0, 1'b1, 32'h31, 8'h88, 4'd8);
      end
      n_tests++;
      if (M_DataRdy !== e_rdy || M_Rdata_ram !== e_dat || err_conflict !== e_conf || err_oob !== e_oob) begin
        n_fail++;
        $display("FAIL rbw_model k=%0d rdy=%b/%b rdata=%h/%h (got/req)", k, M_DataRdy, e_rdy, M_Rdata_ram, e_dat);
      end
    end
    n_tests++;
    if (M_Rdata_ram[7:0] !== 8'h11) begin
      n_fail++;
      $display("FAIL read_before_write rdata0=%h, required 11", M_Rdata_ram[7:0]);
    end
    tick();
    idle();
    init_we = 1'b1; init_addr = 32'h32; init_data = 8'h99;
    req(0, 1'b0, 1'b1, 32'h32, 8'h44, 4'd8);
    tick();
    idle();
    req(0, 1'b1, 1'b0, 32'h30, 8'h00, 4'd8);
    req(1, 1'b1, 1'b0, 32'h31, 8'h00, 4'd8);
    tick();
    idle();
    req(0, 1'b1, 1'b0, 32'h32, 8'h00, 4'd8);
    for (int k = 1; k <= 2; k++) begin
      tick();
      idle();
      n_tests++;
      if (M_DataRdy !== e_rdy || M_Rdata_ram !== e_dat || err_conflict !== e_conf || err_oob !== e_oob) begin
        n_fail++;
        $display("FAIL hazard_model k=%0d rdy=%b/%b rdata=%h/%h (got/req)", k, M_DataRdy, e_rdy, M_Rdata_ram, e_dat);
      end
      n_tests++;
      if (k == 1 && M_Rdata_ram !== 16'h8822) begin
        n_fail++;
        $display("FAIL dual_write_ch1_wins rdata=%h, required 8822", M_Rdata_ram);
      end else if (k == 2 && M_Rdata_ram[7:0] !== 8'h44) begin
        n_fail++;
        $display("FAIL init_vs_channel rdata0=%h, required 44", M_Rdata_ram[7:0]);
      end
    end
  endtask

  task automatic test_oob_conflict();
    req(0, 1'b1, 1'b0, BASE + 32'(DEPTH), 8'h00, 4'd8);
    for (int k = 1; k <= 4; k++) begin
      tick();
      idle();
      n_tests++;
      if (M_DataRdy !== e_rdy || M_Rdata_ram !== e_dat || err_conflict !== e_conf || err_oob !== e_oob) begin
        n_fail++;
        $display("FAIL oob_model k=%0d rdy=%b/%b rdata=%h/%h oob=%b/%b (got/req)", k, M_DataRdy, e_rdy, M_Rdata_ram, e_dat, err_oob, e_oob);
      end
      n_tests++;
      if (err_oob !== 1'b1 || M_DataRdy[0] !== (k == 2) || M_Rdata_ram[7:0] !== 8'h00) begin
        n_fail++;
        $display("FAIL oob_read k=%0d oob=%b rdy0=%b rdata0=%h, required 1 %b 00", k, err_oob, M_DataRdy[0], M_Rdata_ram[7:0], (k == 2));
      end
    end
    req(1, 1'b1, 1'b1, 32'h50, 8'h66, 4'd8);
    tick();
    idle();
    n_tests++;
    if (err_conflict !== 1'b1 || M_DataRdy[1] !== 1'b1 || M_Rdata_ram[15:8] !== 8'h00) begin
      n_fail++;
      $display("FAIL conflict conf=%b rdy1=%b rdata1=%h, required 1 1 00", err_conflict, M_DataRdy[1], M_Rdata_ram[15:8]);
    end
  endtask

  task automatic test_back_to_back();
    int r;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < CH; c++) begin
        r = $urandom_range(0, 9);
        req(c, (r < 4) || (r == 9), (r >= 4 && r < 8) || (r == 9),
            ($urandom_range(0, 19) == 0) ? 32'(DEPTH) + $urandom_range(0, 15) :
            (($urandom_range(0, 1) == 0) ? 32'h60 + $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1)),
            8'($urandom), 4'($urandom));
      end
      if ($urandom_range(0, 7) == 0) begin
        init_we = 1'b1;
        init_addr = 32'h60 + $urandom_range(0, 200);
        init_data = 8'($urandom);
      end
      tick();
      idle();
      n_tests++;
      if (M_DataRdy !== e_rdy || M_Rdata_ram !== e_dat || err_conflict !== e_conf || err_oob !== e_oob) begin
        n_fail++;
        $display("FAIL random cyc=%0d rdy=%b/%b rdata=%h/%h conf=%b/%b oob=%b/%b (got/req)",
                 cyc, M_DataRdy, e_rdy, M_Rdata_ram, e_dat, err_conflict, e_conf, err_oob, e_oob);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (M_DataRdy !== e_rdy || M_Rdata_ram !== e_dat) begin
        n_fail++;
        $display("FAIL random_drain cyc=%0d rdy=%b/%b rdata=%h/%h (got/req)", cyc, M_DataRdy, e_rdy, M_Rdata_ram, e_dat);
      end
    end
  endtask

  task automatic test_reset_inflight();
    logic [7:0] saved;
    saved = mem_m[8'h10];
    req(0, 1'b1, 1'b0, 32'h10, 8'h00, 4'd8);
    tick();
    idle();
    reset = 1'b0;
    sched_v.delete();
    sched_d.delete();
    conf_m = 1'b0;
    oob_m  = 1'b0;
    #1;
    n_tests++;
    if (M_DataRdy !== '0 || M_Rdata_ram !== '0 || err_conflict !== 1'b0 || err_oob !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset rdy=%b rdata=%h conf=%b oob=%b, required all zero", M_DataRdy, M_Rdata_ram, err_conflict, err_oob);
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) reset = 1'b1;
      tick();
      n_tests++;
      if (M_DataRdy !== '0 || M_Rdata_ram !== '0 || err_conflict !== 1'b0 || err_oob !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_drop k=%0d rdy=%b rdata=%h conf=%b oob=%b, required all zero", k, M_DataRdy, M_Rdata_ram, err_conflict, err_oob);
      end
    end
    req(0, 1'b1, 1'b0, 32'h10, 8'h00, 4'd8);
    tick();
    idle();
    tick();
    n_tests++;
    if (M_DataRdy[0] !== 1'b1 || M_Rdata_ram[7:0] !== saved) begin
      n_fail++;
      $display("FAIL mem_kept_over_reset rdy0=%b rdata0=%h, required 1 %h", M_DataRdy[0], M_Rdata_ram[7:0], saved);
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_read();
    test_partial_write();
    test_hazards();
    test_oob_conflict();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
